// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: pipeline-register
// command codes, the controller state enum and the source/destination
// compare used by the load-use interlock.
package pipe_pkg;

  localparam logic [1:0] UPD_HOLD  = 2'b00;
  localparam logic [1:0] UPD_ADV   = 2'b01;
  localparam logic [1:0] UPD_FLUSH = 2'b10;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    WAIT = 2'b01,
    HALT = 2'b10
  } state_e;

  // A D-stage source depends on the E-stage destination when it is read,
  // names the same register file (bit 5 vs rw bit 1) and the same index.
  function automatic logic src_hit(input logic       use_src,
                                   input logic [5:0] src,
                                   input logic [1:0] rw,
                                   input logic [4:0] rd);
    return use_src && (src[5] == rw[1]) && (src[4:0] == rd);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its controller.
// master: the datapath side (drives stage info, receives commands).
// slave:  the controller side.
interface pipe_ctrl_if;
  logic [5:0] d_rs;
  logic [5:0] d_rt;
  logic       d_use_rs;
  logic       d_use_rt;
  logic [1:0] de_rw;
  logic [4:0] de_rd;
  logic       de_is_load;
  logic [4:0] de_wait_time;
  logic       de_redirect;
  logic       de_stop;
  logic [1:0] fd_update;
  logic [1:0] de_update;
  logic [1:0] ew_update;
  logic       pc_en;
  logic       halted;

  modport master (
    output d_rs, d_rt, d_use_rs, d_use_rt,
    output de_rw, de_rd, de_is_load, de_wait_time, de_redirect, de_stop,
    input  fd_update, de_update, ew_update, pc_en, halted
  );

  modport slave (
    input  d_rs, d_rt, d_use_rs, d_use_rt,
    input  de_rw, de_rd, de_is_load, de_wait_time, de_redirect, de_stop,
    output fd_update, de_update, ew_update, pc_en, halted
  );
endinterface

// File: rtl/pipe_ctrl_load_use_detect.sv
// Load-use hazard detector: flags a D-stage instruction that reads the
// register an E-stage load is about to write. Purely combinational.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic [5:0] d_rs,
  input  logic [5:0] d_rt,
  input  logic       d_use_rs,
  input  logic       d_use_rt,
  input  logic [1:0] de_rw,
  input  logic [4:0] de_rd,
  input  logic       de_is_load,
  output logic       hit
);

  // Hazard only when E is a load that actually writes a register.
  always_comb begin
    hit = 1'b0;
    if (de_is_load && (de_rw != 2'b00)) begin
      hit = src_hit(d_use_rs, d_rs, de_rw, de_rd) ||
            src_hit(d_use_rt, d_rt, de_rw, de_rd);
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: sequences multi-cycle E-stage occupancy, branch
// redirects, halt and (optionally) the load-use interlock.
// Optional feature: define PIPE_CTRL_LOADUSE_EN to build the load-use
// stall; without it those cycles advance normally.
module pipe_ctrl
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  pipe_ctrl_if.slave  pif
);

  state_e     state_r;
  state_e     state_nxt_s;
  logic [4:0] cnt_r;
  logic [4:0] cnt_nxt_s;
  logic       complete_s;
  logic       load_use_s;
  logic [1:0] fd_s;
  logic [1:0] de_s;
  logic [1:0] ew_s;
  logic       pc_en_s;
  logic       halted_s;

`ifdef PIPE_CTRL_LOADUSE_EN
  load_use_detect u_load_use_detect (
    .d_rs       (pif.d_rs),
    .d_rt       (pif.d_rt),
    .d_use_rs   (pif.d_use_rs),
    .d_use_rt   (pif.d_use_rt),
    .de_rw      (pif.de_rw),
    .de_rd      (pif.de_rd),
    .de_is_load (pif.de_is_load),
    .hit        (load_use_s)
  );
`else
  logic unused_lu_inputs;
  assign load_use_s       = 1'b0;
  assign unused_lu_inputs = ^{pif.d_rs, pif.d_rt, pif.d_use_rs, pif.d_use_rt,
                              pif.de_rw, pif.de_rd, pif.de_is_load};
`endif

  // State and occupancy counter; reset abandons any WAIT/HALT at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= RUN;
      cnt_r   <= 5'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next state and pipeline commands; hazards act only on completing cycles.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    complete_s  = 1'b0;
    fd_s        = UPD_HOLD;
    de_s        = UPD_HOLD;
    ew_s        = UPD_HOLD;
    pc_en_s     = 1'b0;
    halted_s    = 1'b0;

    case (state_r)
      RUN: begin
        if (pif.de_wait_time != 5'd0) begin
          // E stays occupied: keep F/D, bubble into W.
          ew_s        = UPD_FLUSH;
          state_nxt_s = WAIT;
          cnt_nxt_s   = pif.de_wait_time - 5'd1;
        end else begin
          complete_s  = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_r != 5'd0) begin
          ew_s      = UPD_FLUSH;
          cnt_nxt_s = cnt_r - 5'd1;
        end else begin
          complete_s  = 1'b1;
          state_nxt_s = RUN;
        end
      end
      HALT: begin
        halted_s    = 1'b1;
        state_nxt_s = HALT;
      end
      default: begin
        state_nxt_s = RUN;
        cnt_nxt_s   = 5'd0;
      end
    endcase

    if (complete_s) begin
      if (pif.de_stop) begin
        fd_s        = UPD_FLUSH;
        de_s        = UPD_FLUSH;
        ew_s        = UPD_ADV;
        pc_en_s     = 1'b0;
        state_nxt_s = HALT;
      end else if (pif.de_redirect) begin
        fd_s    = UPD_FLUSH;
        de_s    = UPD_FLUSH;
        ew_s    = UPD_ADV;
        pc_en_s = 1'b1;
      end else if (load_use_s) begin
        // Keep the dependent instruction in D, bubble into E.
        fd_s    = UPD_HOLD;
        de_s    = UPD_FLUSH;
        ew_s    = UPD_ADV;
        pc_en_s = 1'b0;
      end else begin
        fd_s    = UPD_ADV;
        de_s    = UPD_ADV;
        ew_s    = UPD_ADV;
        pc_en_s = 1'b1;
      end
    end else begin
      pc_en_s = 1'b0;
    end

    // While reset is held every command is quiescent.
    if (!rstn) begin
      fd_s     = UPD_HOLD;
      de_s     = UPD_HOLD;
      ew_s     = UPD_HOLD;
      pc_en_s  = 1'b0;
      halted_s = 1'b0;
    end else begin
      halted_s = halted_s;
    end
  end

  assign pif.fd_update = fd_s;
  assign pif.de_update = de_s;
  assign pif.ew_update = ew_s;
  assign pif.pc_en     = pc_en_s;
  assign pif.halted    = halted_s;

endmodule
